// File: rtl/adder_pkg.sv
// adder_pkg: FSM state encoding, clog2 helper and default operand width shared by adder consumers
package adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
  localparam int C_WIDTH_DEF = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator: sums frames of adder results onto a registered valid/ready output
// Optional ACC_SATURATE_EN: clamp the frame total at all-ones on overflow instead of wrapping.
module adder_result_accumulator
  import adder_pkg::*;
#(
  parameter int C_WIDTH     = C_WIDTH_DEF,
  parameter int C_COUNT     = 8,
  parameter int C_ACC_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [C_WIDTH:0]            s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [C_ACC_WIDTH-1:0]      m_sum,
  output logic [clog2(C_COUNT):0]     m_count,
  output logic                        m_ovf
);
  localparam int CW = clog2(C_COUNT) + 1;
  state_t state, state_nxt;
  logic [C_ACC_WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_base, cnt_nxt;
  logic ovf, ovf_nxt, accept, final_beat;
  logic [C_ACC_WIDTH:0] sum;
  // IDLE acceptance starts a fresh frame, so stale acc/cnt/ovf are masked rather than cleared
  always_comb begin
    accept     = s_valid && s_ready;
    cnt_base   = state == IDLE ? '0 : cnt;
    final_beat = s_last || cnt_base == CW'(C_COUNT - 1);
    sum        = (state == IDLE ? '0 : {1'b0, acc}) + (C_ACC_WIDTH + 1)'(s_data);
    ovf_nxt    = (state != IDLE && ovf) || sum[C_ACC_WIDTH];
    cnt_nxt    = cnt_base + 1'b1;
`ifdef ACC_SATURATE_EN
    acc_nxt    = ovf_nxt ? '1 : sum[C_ACC_WIDTH-1:0];
`else
    acc_nxt    = sum[C_ACC_WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = clear ? IDLE :
                state == DONE ? (m_ready ? IDLE : DONE) :
                accept ? (final_beat ? DONE : ACCUM) : state;
  always_comb begin
    s_ready = reset && !clear && state != DONE;
    m_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      m_sum   <= '0;
      m_count <= '0;
      m_ovf   <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      if (final_beat) begin
        m_sum   <= acc_nxt;
        m_count <= cnt_nxt;
        m_ovf   <= ovf_nxt;
      end
    end
endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb_adder_result_accumulator: directed plus random frames against a frame-level model, 8- and 6-bit accumulators
module tb_adder_result_accumulator;
  logic clk = 0, reset = 0, clear = 0, s_valid = 0, s_last = 0, m_ready = 0;
  logic [4:0] s_data = 0;
  logic s_ready8, m_valid8, m_ovf8, s_ready6, m_valid6, m_ovf6;
  logic [7:0] m_sum8;
  logic [5:0] m_sum6;
  logic [3:0] m_count8, m_count6;
  int errors = 0, checks = 0;
  int beats[$];
  bit pending = 0;
  int e_cnt, e_sum8, e_sum6;
  bit e_ovf8, e_ovf6;

  adder_result_accumulator #(.C_WIDTH(4), .C_COUNT(8), .C_ACC_WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .clear(clear), .s_valid(s_valid), .s_ready(s_ready8),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid8), .m_ready(m_ready),
    .m_sum(m_sum8), .m_count(m_count8), .m_ovf(m_ovf8));
  adder_result_accumulator #(.C_WIDTH(4), .C_COUNT(8), .C_ACC_WIDTH(6)) u6 (
    .clk(clk), .reset(reset), .clear(clear), .s_valid(s_valid), .s_ready(s_ready6),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid6), .m_ready(m_ready),
    .m_sum(m_sum6), .m_count(m_count6), .m_ovf(m_ovf6));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic close_frame();
    int tot = 0;
    foreach (beats[i]) tot += beats[i];
    e_cnt  = beats.size();
    e_ovf8 = tot > 255;
    e_ovf6 = tot > 63;
`ifdef ACC_SATURATE_EN
    e_sum8 = e_ovf8 ? 255 : tot;
    e_sum6 = e_ovf6 ? 63 : tot;
`else
    e_sum8 = tot % 256;
    e_sum6 = tot % 64;
`endif
    beats.delete();
    pending = 1;
  endtask

  task automatic cycle(input bit v, input int d, input bit l, input bit mr, input bit c);
    @(negedge clk);
    s_valid = v; s_data = d[4:0]; s_last = l; m_ready = mr; clear = c;
    #1;
    check("s_ready8", s_ready8, !pending && !c);
    check("s_ready6", s_ready6, !pending && !c);
    check("m_valid8", m_valid8, pending);
    check("m_valid6", m_valid6, pending);
    if (pending) begin
      check("m_sum8", m_sum8, e_sum8);
      check("m_sum6", m_sum6, e_sum6);
      check("m_count8", m_count8, e_cnt);
      check("m_count6", m_count6, e_cnt);
      check("m_ovf8", m_ovf8, e_ovf8);
      check("m_ovf6", m_ovf6, e_ovf6);
    end
    if (c) begin
      beats.delete();
      pending = 0;
    end else if (pending) begin
      if (mr) pending = 0;
    end else if (v) begin
      beats.push_back(d);
      if (l || beats.size() == 8) close_frame();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready8", s_ready8, 0);
    check("rst_s_ready6", s_ready6, 0);
    check("rst_m_valid8", m_valid8, 0);
    check("rst_m_valid6", m_valid6, 0);
    check("rst_m_sum8", m_sum8, 0);
    check("rst_m_sum6", m_sum6, 0);
    check("rst_m_count8", m_count8, 0);
    check("rst_m_ovf8", m_ovf8, 0);
    check("rst_m_ovf6", m_ovf6, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
  endtask

  initial begin
    #1 check_reset_outputs();
    @(negedge clk); @(negedge clk);
    reset = 1;
    for (int i = 0; i < 8; i++) cycle(1, 30, 0, 1, 0);
    drain();
    cycle(1, 5, 0, 1, 0); cycle(1, 6, 0, 1, 0); cycle(1, 7, 1, 1, 0);
    drain();
    cycle(1, 31, 0, 1, 0); cycle(1, 31, 0, 1, 0); cycle(1, 31, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 2, 1, 1, 0);
    drain();
    cycle(1, 3, 0, 0, 0); cycle(1, 4, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 9, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 1, 1, 1, 0);
    drain();
    for (int i = 0; i < 4; i++) cycle(1, 9, 0, 1, 0);
    cycle(1, 9, 0, 1, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 1, 0);
    drain();
    for (int i = 0; i < 3; i++) cycle(1, 2, 0, 1, 0);
    @(negedge clk);
    s_valid = 0;
    #2 reset = 0;
    #1 check_reset_outputs();
    beats.delete();
    pending = 0;
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 8; i++) cycle(1, 2, 0, 1, 0);
    drain();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
